// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM encoding, datapath mux selects
// and the comparator result bundle.
package gcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operand register input select: external operand or subtractor output.
  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_DIFF = 1'b1;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_t;

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: A/B operand registers, swap-muxed subtractor and comparator.
// The larger operand is always the minuend, so the difference never wraps.
module gcd_dp
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_val,
  output cmp_t             cmp
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH-1:0] diff;

  assign cmp.gt = (a_q > b_q);
  assign cmp.lt = (a_q < b_q);
  assign cmp.eq = !cmp.gt && !cmp.lt;

  assign minuend    = cmp.gt ? a_q : b_q;
  assign subtrahend = cmp.gt ? b_q : a_q;
  assign diff       = minuend - subtrahend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (ld_a) a_q <= (sel == SEL_DIFF) ? diff : a_in;
      if (ld_b) b_q <= (sel == SEL_DIFF) ? diff : b_in;
    end
  end

  assign a_val = a_q;

endmodule

// File: rtl/gcd_unit.sv
// GCD engine top: start/done controller, saturating subtraction counter and
// result register around the gcd_dp datapath. One subtraction per clock.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iter_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic             ld_a;
  logic             ld_b;
  logic             sel;
  logic             zero_op;
  logic [WIDTH-1:0] a_val;
  cmp_t             cmp;

  gcd_dp #(.WIDTH(WIDTH)) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_a  (ld_a),
    .ld_b  (ld_b),
    .sel   (sel),
    .a_in  (a_in),
    .b_in  (b_in),
    .a_val (a_val),
    .cmp   (cmp)
  );

  assign zero_op = (a_in == '0) || (b_in == '0);

  always_comb begin
    ld_a = 1'b0;
    ld_b = 1'b0;
    sel  = SEL_LOAD;
    case (state)
      ST_IDLE: begin
        if (start && !zero_op) begin
          ld_a = 1'b1;
          ld_b = 1'b1;
        end
      end
      ST_CALC: begin
        if (cmp.gt) begin
          ld_a = 1'b1;
          sel  = SEL_DIFF;
        end else if (cmp.lt) begin
          ld_b = 1'b1;
          sel  = SEL_DIFF;
        end
      end
      default: ;
    endcase
  end

  // Zero operands bypass CALC: gcd(x,0)=x, gcd(0,0)=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      result     <= '0;
      iter_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            iter_count <= '0;
            if (zero_op) begin
              result <= (a_in == '0) ? b_in : a_in;
              state  <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (cmp.eq) begin
            result <= a_val;
            state  <= ST_DONE;
          end else if (!(&iter_count)) begin
            iter_count <= iter_count + CNT_ONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gcd_unit.sv
// Directed bench for gcd_unit: vector table run back-to-back, plus hand
// sequences for ignored starts, mid-run reset and counter saturation.
module tb_gcd_unit;

  localparam int W       = 16;
  localparam int MAX_CYC = 70000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] iter_count;

  // Narrow instance to reach counter saturation in few cycles.
  logic         start_s;
  logic [7:0]   a_s;
  logic [7:0]   b_s;
  logic         busy_s;
  logic         done_s;
  logic [7:0]   result_s;
  logic [2:0]   iter_s;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] iter;
    int           lat;
  } vec_t;

  vec_t         vecs[11];
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  gcd_unit #(.WIDTH(W), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .iter_count (iter_count)
  );

  gcd_unit #(.WIDTH(8), .CNT_W(3)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_s),
    .a_in       (a_s),
    .b_in       (b_s),
    .busy       (busy_s),
    .done       (done_s),
    .result     (result_s),
    .iter_count (iter_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no done within cycle budget", name);
  endtask

  // Called at a negedge; returns at the negedge after the done pulse, so the
  // next call issues start back-to-back.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic [W-1:0] it,
                        output int lat, output int busy_cyc);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    @(negedge clk);
    while (!done && lat < MAX_CYC) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!done) timeout("run_op");
    res = result;
    it  = iter_count;
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] it;
    logic [W-1:0] exp_res;
    int           lat;
    int           bcyc;
    int           waited;

    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    start_s  = 1'b0;
    a_s      = '0;
    b_s      = '0;

    vecs[0]  = '{16'd48,    16'd18, 16'd6,  16'd4,     5};
    vecs[1]  = '{16'd7,     16'd7,  16'd7,  16'd0,     1};
    vecs[2]  = '{16'd0,     16'd9,  16'd9,  16'd0,     0};
    vecs[3]  = '{16'd0,     16'd0,  16'd0,  16'd0,     0};
    vecs[4]  = '{16'd9,     16'd0,  16'd9,  16'd0,     0};
    vecs[5]  = '{16'd12,    16'd8,  16'd4,  16'd2,     3};
    vecs[6]  = '{16'd100,   16'd75, 16'd25, 16'd3,     4};
    vecs[7]  = '{16'd13,    16'd5,  16'd1,  16'd5,     6};
    vecs[8]  = '{16'd1,     16'd1,  16'd1,  16'd0,     1};
    vecs[9]  = '{16'd18,    16'd48, 16'd6,  16'd4,     5};
    vecs[10] = '{16'd65535, 16'd1,  16'd1,  16'd65534, 65535};
    foreach (vecs[i]) exp_q.push_back(vecs[i].res);

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_iter", iter_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, it, lat, bcyc);
      exp_res = exp_q.pop_front();
      check($sformatf("vec%0d_result", i), res, exp_res);
      check($sformatf("vec%0d_iter", i), it, vecs[i].iter);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].lat);
    end

    // Start pulsed mid-CALC must be ignored.
    a_in  = 16'd100;
    b_in  = 16'd75;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_in  = 16'd3;
    b_in  = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (!done && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!done) timeout("ignored_start");
    check("ignored_start_wait", waited, 2);
    check("ignored_start_result", result, 25);
    check("ignored_start_iter", iter_count, 3);
    @(negedge clk);
    check("ignored_start_done_drop", done, 0);

    run_op(16'd3, 16'd9, res, it, lat, bcyc);
    check("b2b_result", res, 3);
    check("b2b_iter", it, 2);
    check("b2b_latency", lat, 3);

    // Asynchronous reset in the middle of a long run.
    a_in  = 16'd1000;
    b_in  = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_iter", iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);
    end
    run_op(16'd12, 16'd8, res, it, lat, bcyc);
    check("post_rst_result", res, 4);
    check("post_rst_iter", it, 2);

    // 8 subtractions against a 3-bit counter: saturates at 7, still completes.
    a_s     = 8'd9;
    b_s     = 8'd1;
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!done_s && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!done_s) timeout("sat_run");
    check("sat_latency", waited, 9);
    check("sat_result", result_s, 1);
    check("sat_iter", iter_s, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
